// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: FSM states, aluop codes and op decode helpers.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h22;
    localparam logic [7:0] OP_LBU = 8'h23;
    localparam logic [7:0] OP_LHU = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2a;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Index of the final byte of the access (N-1 for N = 1/2/4).
    function automatic logic [1:0] last_idx(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of the assembled load word according to the load opcode.
module load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [7:0]  aluop,
    output logic [31:0] ext
);

    always_comb begin
        case (aluop)
            OP_LB:   ext = {{24{acc[7]}}, acc[7:0]};
            OP_LBU:  ext = {24'h0, acc[7:0]};
            OP_LH:   ext = {{16{acc[15]}}, acc[15:0]};
            OP_LHU:  ext = {16'h0, acc[15:0]};
            default: ext = acc;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes non-memory ops through, serialises loads/stores into
// little-endian byte transfers and stalls the pipeline until they finish.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REGADDR_W = 5,
    parameter int unsigned OP_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_wb_i,
    input  logic [DATA_W-1:0]    ex_rd_data_i,
    input  logic [REGADDR_W-1:0] ex_rd_addr_i,
    input  logic                 ex_rd_enable_i,
    input  logic [OP_W-1:0]      ex_aluop_i,
    input  logic [ADDR_W-1:0]    ex_mem_addr_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [7:0]           mem_wdata_o,
    input  logic [7:0]           mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic                 stallreq_o,
    output logic [DATA_W-1:0]    wb_rd_data_o,
    output logic [REGADDR_W-1:0] wb_rd_addr_o,
    output logic                 wb_rd_enable_o
);

    state_t      state, state_nx;
    logic [1:0]  cnt;
    logic [31:0] acc;
    logic [31:0] ext;
    logic [7:0]  op;

    assign op = 8'(ex_aluop_i);

    load_ext u_load_ext (
        .acc   (acc),
        .aluop (op),
        .ext   (ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            if (state == BUSY && mem_ack_i) begin
                if (is_load(op))
                    acc[{cnt, 3'b000} +: 8] <= mem_rdata_i;
                if (cnt == last_idx(op))
                    cnt <= '0;
                else
                    cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        stallreq_o     = 1'b0;
        wb_rd_data_o   = '0;
        wb_rd_addr_o   = '0;
        wb_rd_enable_o = 1'b0;

        case (state)
            IDLE: begin
                if (is_load(op) || is_store(op)) begin
                    state_nx = BUSY;
                end else begin
                    wb_rd_data_o   = ex_rd_data_i;
                    wb_rd_addr_o   = ex_rd_addr_i;
                    wb_rd_enable_o = ex_rd_enable_i;
                end
            end
            BUSY: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ex_mem_addr_i + ADDR_W'(cnt);
                stallreq_o = 1'b1;
                if (is_store(op)) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = ex_rd_data_i[{cnt, 3'b000} +: 8];
                end
                if (mem_ack_i && cnt == last_idx(op))
                    state_nx = DONE;
            end
            DONE: begin
                wb_rd_addr_o = ex_rd_addr_i;
                if (is_load(op)) begin
                    wb_rd_data_o   = DATA_W'(ext);
                    wb_rd_enable_o = ex_rd_enable_i;
                end
                if (!stall_wb_i)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Reset forces every output low without waiting for the register update.
        if (!rst) begin
            mem_req_o      = 1'b0;
            mem_we_o       = 1'b0;
            mem_addr_o     = '0;
            mem_wdata_o    = '0;
            stallreq_o     = 1'b0;
            wb_rd_data_o   = '0;
            wb_rd_addr_o   = '0;
            wb_rd_enable_o = 1'b0;
        end
    end

endmodule
